lzw_symbol_source: RTL and testbench

Parametrised, RAM-backed symbol streamer that feeds the LZW compressor input path. Test or host logic loads symbols through a write port. A `start` command then replays a programmable number of them on a valid/ready stream with a last-symbol marker. The block supports full back-pressure, sustained one-symbol-per-cycle throughput, optional looping and abort.

---
 rtl/lzw_symbol_source.sv | 160 ++++++++++++++++
 tb/tb_lzw_symbol_source.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzw_symbol_source.sv
// rtl/lzw_symbol_source.sv - RAM-backed symbol streamer with valid/ready output, looping and abort.
module lzw_symbol_source #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4096,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  loop_en,
    input  logic                  abort,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DRAIN} state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH:0]     len_q;
    logic [ADDR_WIDTH:0]     len_d;
    logic                    rd_vld_q;
    logic                    rd_last_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic [DATA_WIDTH-1:0]   buf0_q;
    logic [DATA_WIDTH-1:0]   buf1_q;
    logic                    last0_q;
    logic                    last1_q;
    logic [1:0]              cnt_q;
    logic                    done_zero_q;

    logic                    fire;
    logic                    issue;
    logic                    addr_last;
    logic                    final_xfer;
    logic [1:0]              occ;

    // A slot freed by a same-cycle transfer may be refilled, which keeps one symbol per cycle.
    always_comb begin
        len_d      = (length > DEPTH_L) ? DEPTH_L : length;
        occ        = cnt_q + {1'b0, rd_vld_q};
        fire       = out_valid && out_ready;
        addr_last  = ({1'b0, addr_q} == (len_q - 1'b1));
        issue      = (state_q == ST_STREAM) && !abort && ((occ - {1'b0, fire}) < 2'd2);
        final_xfer = (state_q == ST_DRAIN) && !abort && fire && last0_q && (occ == 2'd1);
    end

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = buf0_q;
    assign out_last  = out_valid && last0_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_zero_q || final_xfer;

    always_ff @(posedge clk) begin
        if (wr_en && state_q == ST_IDLE) begin
            mem[wr_addr] <= wr_data;
        end
        if (issue) begin
            rd_data_q <= mem[addr_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            last0_q     <= 1'b0;
            last1_q     <= 1'b0;
            cnt_q       <= 2'd0;
            done_zero_q <= 1'b0;
        end else begin
            done_zero_q <= 1'b0;
            rd_vld_q    <= issue;
            rd_last_q   <= issue && addr_last;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        len_q  <= len_d;
                        addr_q <= '0;
                        if (len_d == '0) begin
                            done_zero_q <= 1'b1;
                        end else begin
                            state_q <= ST_STREAM;
                        end
                    end
                end
                ST_STREAM: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                    end else if (issue) begin
                        if (addr_last) begin
                            addr_q <= '0;
                            if (!loop_en) state_q <= ST_DRAIN;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort || final_xfer) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase

            // Two-entry buffer: head in slot 0, push lands behind whatever survives the pop.
            if (abort && state_q != ST_IDLE) begin
                cnt_q <= 2'd0;
            end else begin
                case ({rd_vld_q, fire})
                    2'b01: begin
                        buf0_q  <= buf1_q;
                        last0_q <= last1_q;
                        cnt_q   <= cnt_q - 2'd1;
                    end
                    2'b10: begin
                        if (cnt_q == 2'd0) begin
                            buf0_q  <= rd_data_q;
                            last0_q <= rd_last_q;
                        end else begin
                            buf1_q  <= rd_data_q;
                            last1_q <= rd_last_q;
                        end
                        cnt_q <= cnt_q + 2'd1;
                    end
                    2'b11: begin
                        if (cnt_q == 2'd1) begin
                            buf0_q  <= rd_data_q;
                            last0_q <= rd_last_q;
                        end else begin
                            buf0_q  <= buf1_q;
                            last0_q <= last1_q;
                            buf1_q  <= rd_data_q;
                            last1_q <= rd_last_q;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lzw_symbol_source.sv
// tb/tb_lzw_symbol_source.sv - scoreboard bench for lzw_symbol_source.
module tb_lzw_symbol_source;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic [AW:0]   length;
    logic          loop_en;
    logic          abort;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    lzw_symbol_source #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .INIT_FILE("")
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .length(length), .loop_en(loop_en), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic          f;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] abba [11] = '{8'd65, 8'd66, 8'd66, 8'd65, 8'd66, 8'd66, 8'd66, 8'd65, 8'd66, 8'd66, 8'd65};
    int            checks = 0;
    int            errors = 0;
    int            xfer_cnt = 0;
    int            rmode = 0;
    bit            zero_pending = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Consumer ready: 0 always high, 1 pattern 1,0,0,1, 2 random, 3 always low.
    initial begin
        int ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = (ph % 4 == 0) || (ph % 4 == 3);
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
            ph++;
        end
    end

    // Monitor: pops the scoreboard on every transfer and watches stalls and done.
    initial begin
        bit            prev_stall = 1'b0;
        bit            fin_prev = 1'b0;
        logic [DW-1:0] prev_data = '0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                fin_prev   = 1'b0;
            end else begin
                if (fin_prev) chk("busy_after_done", 32'(busy), 32'd0);
                fin_prev = 1'b0;
                if (prev_stall && out_valid) chk("stall_hold", 32'(out_data), 32'(prev_data));
                if (out_valid && out_ready) begin
                    xfer_cnt++;
                    if (q.size() == 0) begin
                        chk("unexpected_xfer", 32'(out_data), 32'hFFFF_FFFF);
                    end else begin
                        e = q.pop_front();
                        chk("data", 32'(out_data), 32'(e.d));
                        chk("last", 32'(out_last), 32'(e.l));
                        chk("done_on_xfer", 32'(done), 32'(e.f));
                        fin_prev = e.f;
                    end
                end else if (!zero_pending) begin
                    chk("spurious_done", 32'(done), 32'd0);
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    task automatic write_sym(input int a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        tick();
        wr_en = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic start_stream(input int len, input bit push_exp);
        int n;
        exp_t e;
        n = (len > DEPTH) ? DEPTH : len;
        if (push_exp) begin
            for (int i = 0; i < n; i++) begin
                e.d = model_mem[i];
                e.l = (i == n - 1);
                e.f = (i == n - 1);
                q.push_back(e);
            end
        end
        start  = 1'b1;
        length = (AW + 1)'(len);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (!busy && q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
        tick();
    endtask

    task automatic wait_xfers(input string name, input int target);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (xfer_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    initial begin
        int   k;
        int   base;
        exp_t e;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        length  = '0;
        loop_en = 1'b0;
        abort   = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < DEPTH; i++) write_sym(i, (i < 11) ? abba[i] : DW'($urandom));

        // Full-rate pass: check start latency and done timing.
        rmode = 0;
        start_stream(11, 1'b1);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("valid_e0", 32'(out_valid), 32'd0);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 1) chk("valid_e1", 32'(out_valid), 32'd0);
            if (i == 2) chk("valid_e2", 32'(out_valid), 32'd1);
            if (done) begin
                k = i;
                break;
            end
        end
        chk("done_edge", 32'(k), 32'd12);
        wait_idle("idle_full", 100);

        rmode = 1;
        start_stream(11, 1'b1);
        wait_idle("idle_toggle", 200);

        // Zero length.
        rmode = 0;
        zero_pending = 1'b1;
        start_stream(0, 1'b0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_valid", 32'(out_valid), 32'd0);
        tick();
        chk("zero_done_clr", 32'(done), 32'd0);
        chk("zero_busy2", 32'(busy), 32'd0);
        zero_pending = 1'b0;
        tick();

        // Loop over 3 symbols, stop looping before the third pass wraps.
        for (int i = 0; i < 9; i++) begin
            e.d = abba[i % 3];
            e.l = (i % 3 == 2);
            e.f = (i == 8);
            q.push_back(e);
        end
        base = xfer_cnt;
        loop_en = 1'b1;
        start_stream(3, 1'b0);
        wait_xfers("loop_seven", base + 7);
        loop_en = 1'b0;
        wait_idle("idle_loop", 100);

        // Abort with a write attempted while busy.
        start_stream(11, 1'b1);
        base = xfer_cnt;
        wait_xfers("abort_four", base + 4);
        wr_en   = 1'b1;
        wr_addr = 4'd1;
        wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        q.delete();
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        tick();
        start_stream(11, 1'b1);
        wait_idle("idle_after_abort", 100);

        // Reset during a stalled transfer.
        rmode = 3;
        start_stream(5, 1'b1);
        repeat (4) tick();
        chk("stalled_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_last", 32'(out_last), 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        q.delete();
        tick();
        rst_n = 1'b1;
        rmode = 0;
        tick();
        start_stream(11, 1'b1);
        wait_idle("idle_after_reset", 100);

        // Random contents, lengths (including clamp above DEPTH) and back-pressure.
        for (int it = 0; it < 8; it++) begin
            rmode = 0;
            for (int w = 0; w < 3; w++) write_sym($urandom_range(0, DEPTH - 1), DW'($urandom));
            rmode = 2;
            start_stream($urandom_range(1, 31), 1'b1);
            wait_idle("idle_random", 400);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
